// File: rtl/msp430_control_unit.sv
// MSP430-style instruction sequencer: fetch, decode, extension-word fetch, execute/write-back and jumps.
// Optional MSP430_ILLEGAL_TRAP_EN: illegal opcodes halt with Illegal=1 instead of acting as a NOP.
module msp430_control_unit (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] Instr,
    input  logic        Mem_ack,
    input  logic [3:0]  Flags,
    output logic [4:0]  Fsm,
    output logic        Mem_req,
    output logic        PC_inc,
    output logic        Ir_ld,
    output logic [1:0]  Ext_ld,
    output logic [3:0]  Src_reg,
    output logic [3:0]  Dst_reg,
    output logic [3:0]  Alu_op,
    output logic [1:0]  Fmt,
    output logic        Wr_en,
    output logic        Jmp_ld,
    output logic [9:0]  PC_offset,
    output logic        Illegal
);

    typedef enum logic [4:0] {
        S_RESET  = 5'd0,
        S_FETCH  = 5'd1,
        S_DECODE = 5'd2,
        S_EXT1   = 5'd3,
        S_EXT2   = 5'd4,
        S_EXEC   = 5'd5,
        S_WB     = 5'd6,
        S_JUMP   = 5'd7,
        S_HALT   = 5'd8
    } state_t;

    localparam logic [1:0] FMT_NONE   = 2'd0;
    localparam logic [1:0] FMT_DOUBLE = 2'd1;
    localparam logic [1:0] FMT_SINGLE = 2'd2;
    localparam logic [1:0] FMT_JUMP   = 2'd3;

    state_t      state;
    state_t      state_next;
    logic [15:0] ir;
    logic        ack;
    logic        is_jump;
    logic        is_double;
    logic        is_single;
    logic        src_ext;
    logic [1:0]  ext_cnt;
    logic        jump_taken;
    logic        wb_write;
    logic        flag_v;
    logic        flag_n;
    logic        flag_z;
    logic        flag_c;
    logic        unused_bw;

    // Memory handshake: Mem_req is held for the whole FETCH/EXT state; the word
    // is taken in the cycle Mem_ack=1 is seen (possibly the first request cycle).
    // Reset suppresses the request and ignores any ack.
    assign ack = Mem_ack & ~Rst;

    // Byte/word select does not influence sequencing.
    assign unused_bw = ir[6];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_RESET;
            ir    <= 16'h0000;
        end else begin
            state <= state_next;
            if (Ir_ld) begin
                ir <= Instr;
            end
        end
    end

    // Instruction classification from the latched word.
    assign is_jump   = (ir[15:13] == 3'b001);
    assign is_double = (ir[15:12] >= 4'd4);
    assign is_single = (ir[15:10] == 6'b000100);

    always_comb begin
        Fmt       = FMT_NONE;
        Alu_op    = 4'd0;
        Src_reg   = 4'd0;
        Dst_reg   = 4'd0;
        PC_offset = 10'd0;
        src_ext   = 1'b0;
        ext_cnt   = 2'd0;
        if (is_jump) begin
            Fmt       = FMT_JUMP;
            PC_offset = ir[9:0];
        end else if (is_double) begin
            Fmt     = FMT_DOUBLE;
            Alu_op  = ir[15:12];
            Src_reg = ir[11:8];
            Dst_reg = ir[3:0];
            // Indexed source, or immediate (@PC+ with PC as source).
            src_ext = (ir[5:4] == 2'b01) || ((ir[5:4] == 2'b11) && (ir[11:8] == 4'd0));
            ext_cnt = {1'b0, src_ext} + {1'b0, ir[7]};
        end else if (is_single) begin
            Fmt     = FMT_SINGLE;
            Alu_op  = {1'b0, ir[9:7]};
            Src_reg = ir[3:0];
            Dst_reg = ir[3:0];
            src_ext = (ir[5:4] == 2'b01) || ((ir[5:4] == 2'b11) && (ir[3:0] == 4'd0));
            ext_cnt = {1'b0, src_ext};
        end
    end

    assign flag_v = Flags[3];
    assign flag_n = Flags[2];
    assign flag_z = Flags[1];
    assign flag_c = Flags[0];

    always_comb begin
        jump_taken = 1'b0;
        case (ir[12:10])
            3'd0: jump_taken = ~flag_z;
            3'd1: jump_taken = flag_z;
            3'd2: jump_taken = ~flag_c;
            3'd3: jump_taken = flag_c;
            3'd4: jump_taken = flag_n;
            3'd5: jump_taken = ~(flag_n ^ flag_v);
            3'd6: jump_taken = flag_n ^ flag_v;
            default: jump_taken = 1'b1;
        endcase
    end

    // CMP and BIT only update flags, never the destination register.
    assign wb_write = !((Fmt == FMT_DOUBLE) && ((Alu_op == 4'h9) || (Alu_op == 4'hB)));

    always_comb begin
        state_next = state;
        Mem_req    = 1'b0;
        PC_inc     = 1'b0;
        Ir_ld      = 1'b0;
        Ext_ld     = 2'b00;
        Wr_en      = 1'b0;
        Jmp_ld     = 1'b0;
        case (state)
            S_RESET: state_next = S_FETCH;
            S_FETCH: begin
                Mem_req = ~Rst;
                if (ack) begin
                    Ir_ld      = 1'b1;
                    PC_inc     = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (Fmt)
                    FMT_JUMP: state_next = S_JUMP;
                    FMT_DOUBLE, FMT_SINGLE: state_next = (ext_cnt != 2'd0) ? S_EXT1 : S_EXEC;
                    default: begin
`ifdef MSP430_ILLEGAL_TRAP_EN
                        state_next = S_HALT;
`else
                        state_next = S_FETCH;
`endif
                    end
                endcase
            end
            S_EXT1: begin
                Mem_req = ~Rst;
                if (ack) begin
                    PC_inc     = 1'b1;
                    Ext_ld     = 2'b01;
                    state_next = (ext_cnt == 2'd2) ? S_EXT2 : S_EXEC;
                end
            end
            S_EXT2: begin
                Mem_req = ~Rst;
                if (ack) begin
                    PC_inc     = 1'b1;
                    Ext_ld     = 2'b10;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: state_next = S_WB;
            S_WB: begin
                Wr_en      = wb_write & ~Rst;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                Jmp_ld     = jump_taken & ~Rst;
                state_next = S_FETCH;
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_RESET;
        endcase
        if (Rst) begin
            state_next = S_RESET;
        end
    end

    assign Fsm = state;

`ifdef MSP430_ILLEGAL_TRAP_EN
    assign Illegal = (state == S_HALT);
`else
    assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_msp430_control_unit.sv
// Directed bench for msp430_control_unit: per-cycle state/strobe checks against an expected state queue.
module tb_msp430_control_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [15:0] Instr;
    logic        Mem_ack;
    logic [3:0]  Flags;
    logic [4:0]  Fsm;
    logic        Mem_req;
    logic        PC_inc;
    logic        Ir_ld;
    logic [1:0]  Ext_ld;
    logic [3:0]  Src_reg;
    logic [3:0]  Dst_reg;
    logic [3:0]  Alu_op;
    logic [1:0]  Fmt;
    logic        Wr_en;
    logic        Jmp_ld;
    logic [9:0]  PC_offset;
    logic        Illegal;

    int          n_checks = 0;
    int          n_fail = 0;
    int          pcinc_cnt = 0;
    int          base;
    logic [4:0]  exp_q[$];

    msp430_control_unit dut (
        .Clk(Clk), .Rst(Rst), .Instr(Instr), .Mem_ack(Mem_ack), .Flags(Flags),
        .Fsm(Fsm), .Mem_req(Mem_req), .PC_inc(PC_inc), .Ir_ld(Ir_ld), .Ext_ld(Ext_ld),
        .Src_reg(Src_reg), .Dst_reg(Dst_reg), .Alu_op(Alu_op), .Fmt(Fmt),
        .Wr_en(Wr_en), .Jmp_ld(Jmp_ld), .PC_offset(PC_offset), .Illegal(Illegal)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (PC_inc === 1'b1) pcinc_cnt++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic q(input logic [4:0] s);
        exp_q.push_back(s);
    endtask

    // Checks the current cycle (inputs already applied) then advances one clock.
    task automatic cyc(input string tag, input logic req, input logic pinc, input logic irld,
                       input logic [1:0] ext, input logic wr, input logic jmp);
        logic [4:0] e;
        #1;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 5'h1f;
        chk({tag, ".fsm"}, {11'd0, Fsm}, {11'd0, e});
        chk({tag, ".mem_req"}, {15'd0, Mem_req}, {15'd0, req});
        chk({tag, ".pc_inc"}, {15'd0, PC_inc}, {15'd0, pinc});
        chk({tag, ".ir_ld"}, {15'd0, Ir_ld}, {15'd0, irld});
        chk({tag, ".ext_ld"}, {14'd0, Ext_ld}, {14'd0, ext});
        chk({tag, ".wr_en"}, {15'd0, Wr_en}, {15'd0, wr});
        chk({tag, ".jmp_ld"}, {15'd0, Jmp_ld}, {15'd0, jmp});
        @(posedge Clk);
        #1;
    endtask

    task automatic fields(input string tag, input logic [3:0] src, input logic [3:0] dst,
                          input logic [3:0] alu, input logic [1:0] fmt, input logic [9:0] off,
                          input logic ill);
        chk({tag, ".src"}, {12'd0, Src_reg}, {12'd0, src});
        chk({tag, ".dst"}, {12'd0, Dst_reg}, {12'd0, dst});
        chk({tag, ".alu"}, {12'd0, Alu_op}, {12'd0, alu});
        chk({tag, ".fmt"}, {14'd0, Fmt}, {14'd0, fmt});
        chk({tag, ".off"}, {6'd0, PC_offset}, {6'd0, off});
        chk({tag, ".illegal"}, {15'd0, Illegal}, {15'd0, ill});
    endtask

    // One fetch-ack cycle (from FETCH) followed by DECODE, ending at the next state.
    task automatic fetch_decode(input string tag, input logic [15:0] word);
        Instr = word; Mem_ack = 1'b1;
        q(1); cyc({tag, ".fetch"}, 1, 1, 1, 2'b00, 0, 0);
        Mem_ack = 1'b0; Instr = 16'hFFFF;
        q(2); cyc({tag, ".decode"}, 0, 0, 0, 2'b00, 0, 0);
    endtask

    task automatic do_jump(input string tag, input logic [15:0] word, input logic [3:0] fl,
                           input logic taken);
        fetch_decode(tag, word);
        Flags = fl;
        fields({tag, ".jump"}, 0, 0, 0, 2'd3, word[9:0], 0);
        q(7); cyc({tag, ".jump"}, 0, 0, 0, 2'b00, 0, taken);
        Flags = 4'b0000;
    endtask

    initial begin
        Rst = 1'b1; Mem_ack = 1'b1; Instr = 16'hFFFF; Flags = 4'b0000;
        @(posedge Clk);
        #1;
        // Reset held with a stray ack: everything quiet.
        q(0); cyc("rst_hold", 0, 0, 0, 2'b00, 0, 0);
        fields("rst_hold", 0, 0, 0, 2'd0, 10'd0, 0);
        Rst = 1'b0; Mem_ack = 1'b0;
        q(0); cyc("rst_rel", 0, 0, 0, 2'b00, 0, 0);

        // MOV R4,R5
        base = pcinc_cnt;
        Instr = 16'h4405; Mem_ack = 1'b1;
        q(1); cyc("mov.fetch", 1, 1, 1, 2'b00, 0, 0);
        Mem_ack = 1'b0; Instr = 16'hFFFF;
        fields("mov.decode", 4, 5, 4, 2'd1, 10'd0, 0);
        q(2); cyc("mov.decode", 0, 0, 0, 2'b00, 0, 0);
        q(5); cyc("mov.exec", 0, 0, 0, 2'b00, 0, 0);
        q(6); cyc("mov.wb", 0, 0, 0, 2'b00, 1, 0);
        fields("mov.next_fetch", 4, 5, 4, 2'd1, 10'd0, 0);
        chk("mov.pc_inc_count", 16'(pcinc_cnt - base), 16'd1);

        // CMP R4,R5: no register write
        fetch_decode("cmp", 16'h9405);
        fields("cmp", 4, 5, 9, 2'd1, 10'd0, 0);
        q(5); cyc("cmp.exec", 0, 0, 0, 2'b00, 0, 0);
        q(6); cyc("cmp.wb", 0, 0, 0, 2'b00, 0, 0);

        // JEQ +5 taken / not taken; JGE with N^V=1 not taken; JMP always
        do_jump("jeq_z1", 16'h2405, 4'b0010, 1);
        do_jump("jeq_z0", 16'h2405, 4'b0000, 0);
        do_jump("jge_nv", 16'h3405, 4'b1000, 0);
        do_jump("jmp", 16'h3FFF, 4'b0000, 1);

        // MOV #imm,x(R5): two extension words, first ack delayed one cycle
        base = pcinc_cnt;
        fetch_decode("movx", 16'h40B5);
        fields("movx", 0, 5, 4, 2'd1, 10'd0, 0);
        q(3); cyc("movx.ext1_wait", 1, 0, 0, 2'b00, 0, 0);
        Mem_ack = 1'b1; Instr = 16'h1234;
        q(3); cyc("movx.ext1", 1, 1, 0, 2'b01, 0, 0);
        Instr = 16'h5678;
        q(4); cyc("movx.ext2", 1, 1, 0, 2'b10, 0, 0);
        Mem_ack = 1'b0;
        q(5); cyc("movx.exec", 0, 0, 0, 2'b00, 0, 0);
        q(6); cyc("movx.wb", 0, 0, 0, 2'b00, 1, 0);
        chk("movx.pc_inc_count", 16'(pcinc_cnt - base), 16'd3);

        // Single-operand SWPB x(R5): one extension word
        fetch_decode("swpb", 16'h1095);
        fields("swpb", 5, 5, 1, 2'd2, 10'd0, 0);
        Mem_ack = 1'b1; Instr = 16'h0010;
        q(3); cyc("swpb.ext1", 1, 1, 0, 2'b01, 0, 0);
        Mem_ack = 1'b0;
        q(5); cyc("swpb.exec", 0, 0, 0, 2'b00, 0, 0);
        q(6); cyc("swpb.wb", 0, 0, 0, 2'b00, 1, 0);

        // Fetch ack delayed three cycles, then reset during EXEC
        base = pcinc_cnt;
        for (int i = 0; i < 3; i++) begin
            q(1); cyc("slow.wait", 1, 0, 0, 2'b00, 0, 0);
        end
        fetch_decode("slow", 16'h5405);
        chk("slow.pc_inc_count", 16'(pcinc_cnt - base), 16'd1);
        Rst = 1'b1;
        q(5); cyc("slow.exec_rst", 0, 0, 0, 2'b00, 0, 0);
        fields("slow.after_rst", 0, 0, 0, 2'd0, 10'd0, 0);
        q(0); cyc("slow.in_rst", 0, 0, 0, 2'b00, 0, 0);
        Rst = 1'b0;
        q(0); cyc("slow.rst_rel", 0, 0, 0, 2'b00, 0, 0);

        // Reset in the middle of a fetch handshake: ack is ignored
        q(1); cyc("mid.wait", 1, 0, 0, 2'b00, 0, 0);
        Rst = 1'b1; Mem_ack = 1'b1; Instr = 16'h4405;
        q(1); cyc("mid.rst_ack", 0, 0, 0, 2'b00, 0, 0);
        Rst = 1'b0; Mem_ack = 1'b0;
        fields("mid.no_load", 0, 0, 0, 2'd0, 10'd0, 0);
        q(0); cyc("mid.reset_state", 0, 0, 0, 2'b00, 0, 0);

        // Illegal opcode 0x0000
        fetch_decode("ill", 16'h0000);
`ifdef MSP430_ILLEGAL_TRAP_EN
        fields("ill.halt", 0, 0, 0, 2'd0, 10'd0, 1);
        q(8); cyc("ill.halt1", 0, 0, 0, 2'b00, 0, 0);
        Mem_ack = 1'b1;
        q(8); cyc("ill.halt2", 0, 0, 0, 2'b00, 0, 0);
        Mem_ack = 1'b0;
        fields("ill.still", 0, 0, 0, 2'd0, 10'd0, 1);
        Rst = 1'b1;
        q(8); cyc("ill.rst", 0, 0, 0, 2'b00, 0, 0);
        fields("ill.cleared", 0, 0, 0, 2'd0, 10'd0, 0);
        Rst = 1'b0;
        q(0); cyc("ill.rst_rel", 0, 0, 0, 2'b00, 0, 0);
`else
        fields("ill.nop", 0, 0, 0, 2'd0, 10'd0, 0);
        q(1); cyc("ill.back_to_fetch", 1, 0, 0, 2'b00, 0, 0);
`endif

        // Normal operation resumes after the illegal word
        fetch_decode("post", 16'h4405);
        q(5); cyc("post.exec", 0, 0, 0, 2'b00, 0, 0);
        q(6); cyc("post.wb", 0, 0, 0, 2'b00, 1, 0);

        chk("exp_q_drained", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
